branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
- Consumer of the {Z,V,N} flag state: evaluates the 3-bit branch condition against current flags and resolves branch direction and target.
- Holds a branch while a flag-setting instruction is still in flight.
- Issues a registered PC redirect and pipeline flush on mispredict.
- Sits in the decode/execute boundary between the flag register's passthrough output and the fetch PC mux; also keeps saturating branch statistics.

Parameters:
- PC_W, 16, PC and target width
- IMM_W, 9, branch immediate width in halfwords, signed
- CNT_W, 16, statistics counter width

Ports:
- clk  input  1  clock, posedge
- rst  input  1  asynchronous, active-low reset
- br_valid  input  1  branch instruction presented
- br_ready  output  1  resolver can accept a branch this cycle
- br_cond  input  3  condition code
- br_is_reg  input  1  0 = B (PC-relative), 1 = BR (register target)
- br_pred_taken  input  1  fetch-time prediction
- br_pc_plus2  input  PC_W  address of next sequential instruction
- br_imm  input  IMM_W  signed halfword offset
- br_reg_target  input  PC_W  register target for BR
- flagZVN_in  input  3  {Z,V,N} current flags (passthrough view)
- flag_pending  input  1  older flag-writing instruction not yet written
- stall  output  1  hold fetch/decode
- redirect_valid  output  1  one-cycle pulse: load redirect_pc
- redirect_pc  output  PC_W  corrected fetch address
- flush  output  1  one-cycle pulse: squash wrong-path instructions
- resolved_taken  output  1  direction of last resolved branch
- branch_count  output  CNT_W  resolved branches, saturating
- mispredict_count  output  CNT_W  mispredicts, saturating

Behaviour:
- Reset (rst=0, async): state IDLE, all outputs 0, counters 0, captured fields 0.
- States:
  - IDLE: br_ready=1, stall=0.
  - WAIT: br_ready=0, stall=1.
  - RESOLVE: br_ready=0, stall=1.
- Capture: in IDLE with br_valid=1, latch cond, is_reg, pred, pc_plus2, imm, reg_target.
  - cond≠111 and flag_pending=1 -> WAIT.
  - Otherwise -> RESOLVE; flags are sampled that same cycle.
- WAIT: stay while flag_pending=1. In the first cycle flag_pending=0, sample flagZVN_in -> RESOLVE. cond 111 never enters WAIT.
- Conditions, on the sampled {Z,V,N}:
  - 000 NE: !Z
  - 001 EQ: Z
  - 010 GT: !Z&!N
  - 011 LT: N
  - 100 GE: Z|!N
  - 101 LE: Z|N
  - 110 OV: V
  - 111 always taken
- Target:
  - is_reg=1: reg_target.
  - is_reg=0: pc_plus2 + (sign-extended imm << 1), modulo 2^PC_W; wrap-around is not an error.
- RESOLVE (one cycle), then -> IDLE:
  - resolved_taken = taken.
  - branch_count increments.
  - If taken≠pred: redirect_valid=1 and flush=1 for exactly this cycle; redirect_pc = taken ? target : pc_plus2; mispredict_count increments.
  - Correct prediction: no redirect/flush.
  - redirect_pc holds its last value when redirect_valid=0.
- Latency: no pending flags -> accept cycle N, redirect cycle N+1. Pending -> redirect one cycle after the flags-clear cycle.
- Throughput: one branch per 2 cycles minimum; br_ready is low in RESOLVE, so back-to-back br_valid waits one cycle.
- Counters saturate at all-ones. Both counters reach max independently; saturation does not affect the redirect.
- br_valid while br_ready=0 is ignored; upstream must hold the branch.
- Reset mid-WAIT or mid-RESOLVE: immediate return to IDLE, no redirect/flush pulse, captured branch discarded.
- Flags are read combinationally from the passthrough view, so a same-cycle flag write is seen in the sample.

Test Plan:
- Z=1, flag_pending=0, cond=001, B, pc_plus2=0x0010, imm=+4, pred=0 -> next cycle redirect_valid=1, flush=1, redirect_pc=0x0018, resolved_taken=1, mispredict_count=1.
- cond=000, Z=1, pred=0 -> not taken, no redirect/flush, branch_count increments, resolved_taken=0.
- cond=010, flag_pending=1 for 3 cycles, then flags {0,0,0} -> stall high 4 cycles, redirect to target exactly one cycle after flag_pending falls (pred=0).
- cond=111, flag_pending=1, BR, reg_target=0xBEEF, pred=0 -> no WAIT, redirect_pc=0xBEEF next cycle.
- pc_plus2=0xFFFE, imm=+2, cond=111, pred=0 -> redirect_pc=0x0002 (wrap). pc_plus2=0x0004, imm=-4 (0x1FC) -> 0xFFFC.
- rst=0 asserted while in WAIT -> outputs 0 immediately, no pulse after release. Preloaded mispredict_count=0xFFFF plus a mispredict -> stays 0xFFFF, flush still pulses.

Source files
------------

// File: rtl/branch_resolver.sv
// Branch resolver: evaluates condition codes against {Z,V,N}, waits out
// in-flight flag writers, issues registered redirect/flush, keeps stats.
module branch_resolver #(
  parameter int PC_W  = 16,
  parameter int IMM_W = 9,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic [2:0]       br_cond,
  input  logic             br_is_reg,
  input  logic             br_pred_taken,
  input  logic [PC_W-1:0]  br_pc_plus2,
  input  logic [IMM_W-1:0] br_imm,
  input  logic [PC_W-1:0]  br_reg_target,
  input  logic [2:0]       flagZVN_in,
  input  logic             flag_pending,
  output logic             stall,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             flush,
  output logic             resolved_taken,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RES  = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       state;
  logic [2:0]       cond_q;
  logic             is_reg_q;
  logic             pred_q;
  logic [PC_W-1:0]  pc_q;
  logic [IMM_W-1:0] imm_q;
  logic [PC_W-1:0]  tgt_q;

  logic             idle;
  logic             go;
  logic [2:0]       cond_s;
  logic             is_reg_s;
  logic             pred_s;
  logic [PC_W-1:0]  pc_s;
  logic [IMM_W-1:0] imm_s;
  logic [PC_W-1:0]  tgt_s;
  logic             z;
  logic             v;
  logic             n;
  logic             taken;
  logic             mis;
  logic [PC_W-1:0]  off;
  logic [PC_W-1:0]  target;

  assign idle     = (state == S_IDLE);
  assign br_ready = rst & idle;
  assign stall    = ~idle;

  // Resolution happens on the edge that enters RESOLVE, so the
  // redirect is visible for exactly the RESOLVE cycle.
  assign go = (idle && br_valid &&
               !(br_cond != 3'b111 && flag_pending)) ||
              (state == S_WAIT && !flag_pending);

  assign cond_s   = idle ? br_cond       : cond_q;
  assign is_reg_s = idle ? br_is_reg     : is_reg_q;
  assign pred_s   = idle ? br_pred_taken : pred_q;
  assign pc_s     = idle ? br_pc_plus2   : pc_q;
  assign imm_s    = idle ? br_imm        : imm_q;
  assign tgt_s    = idle ? br_reg_target : tgt_q;

  assign {z, v, n} = flagZVN_in;

  always_comb begin
    taken = 1'b1;
    unique case (cond_s)
      3'b000:  taken = ~z;
      3'b001:  taken = z;
      3'b010:  taken = ~z & ~n;
      3'b011:  taken = n;
      3'b100:  taken = z | ~n;
      3'b101:  taken = z | n;
      3'b110:  taken = v;
      default: taken = 1'b1;
    endcase
  end

  assign off = {{(PC_W-IMM_W-1){imm_s[IMM_W-1]}}, imm_s, 1'b0};
  assign target = is_reg_s ? tgt_s : pc_s + off;
  assign mis = (taken != pred_s);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cond_q   <= '0;
      is_reg_q <= 1'b0;
      pred_q   <= 1'b0;
      pc_q     <= '0;
      imm_q    <= '0;
      tgt_q    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (br_valid) begin
            cond_q   <= br_cond;
            is_reg_q <= br_is_reg;
            pred_q   <= br_pred_taken;
            pc_q     <= br_pc_plus2;
            imm_q    <= br_imm;
            tgt_q    <= br_reg_target;
            state    <= go ? S_RES : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!flag_pending) state <= S_RES;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redirect_valid   <= 1'b0;
      flush            <= 1'b0;
      redirect_pc      <= '0;
      resolved_taken   <= 1'b0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      redirect_valid <= 1'b0;
      flush          <= 1'b0;
      if (go) begin
        resolved_taken <= taken;
        redirect_valid <= mis;
        flush          <= mis;
        if (mis) redirect_pc <= taken ? target : pc_s;
        if (branch_count != CNT_MAX)
          branch_count <= branch_count + 1'b1;
        if (mis && mispredict_count != CNT_MAX)
          mispredict_count <= mispredict_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver; counters built narrow so that
// saturation is reachable in a short run.
module tb_branch_resolver;

  localparam int PC_W  = 16;
  localparam int IMM_W = 9;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  logic             clk;
  logic             rst;
  logic             br_valid;
  logic             br_ready;
  logic [2:0]       br_cond;
  logic             br_is_reg;
  logic             br_pred_taken;
  logic [PC_W-1:0]  br_pc_plus2;
  logic [IMM_W-1:0] br_imm;
  logic [PC_W-1:0]  br_reg_target;
  logic [2:0]       flagZVN_in;
  logic             flag_pending;
  logic             stall;
  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic             flush;
  logic             resolved_taken;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  branch_resolver #(
    .PC_W(PC_W), .IMM_W(IMM_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .br_valid(br_valid), .br_ready(br_ready),
    .br_cond(br_cond), .br_is_reg(br_is_reg),
    .br_pred_taken(br_pred_taken),
    .br_pc_plus2(br_pc_plus2), .br_imm(br_imm),
    .br_reg_target(br_reg_target),
    .flagZVN_in(flagZVN_in), .flag_pending(flag_pending),
    .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush),
    .resolved_taken(resolved_taken),
    .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  typedef struct {
    logic             mis;
    logic [PC_W-1:0]  pc;
    logic             taken;
    logic [CNT_W-1:0] bc;
    logic [CNT_W-1:0] mc;
  } exp_t;

  exp_t sb[$];
  int n_chk;
  int n_fail;
  logic [PC_W-1:0]  m_rpc;
  logic [CNT_W-1:0] m_b;
  logic [CNT_W-1:0] m_m;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic cond_model(input logic [2:0] c,
                                      input logic [2:0] f);
    logic fz, fv, fn;
    {fz, fv, fn} = f;
    case (c)
      3'd0: return !fz;
      3'd1: return fz;
      3'd2: return !fz && !fn;
      3'd3: return fn;
      3'd4: return fz || !fn;
      3'd5: return fz || fn;
      3'd6: return fv;
      default: return 1'b1;
    endcase
  endfunction

  task automatic issue(input logic [2:0] c, input logic r,
                       input logic p, input logic [15:0] pc,
                       input logic [8:0] imm, input logic [15:0] rt,
                       input logic [2:0] f, input int pend,
                       output int stalls, output int holds);
    exp_t e;
    int eff;
    int off;
    logic [15:0] tgt;
    off = $signed(imm) * 2;
    tgt = r ? rt : 16'(int'(pc) + off);
    e.taken = cond_model(c, f);
    e.mis = (e.taken != p);
    if (e.mis) m_rpc = e.taken ? tgt : pc;
    if (m_b != CMAX) m_b = m_b + 1'b1;
    if (e.mis && m_m != CMAX) m_m = m_m + 1'b1;
    e.pc = m_rpc;
    e.bc = m_b;
    e.mc = m_m;
    sb.push_back(e);
    eff = (c == 3'b111) ? 0 : pend;
    br_valid = 1'b1;
    br_cond = c;
    br_is_reg = r;
    br_pred_taken = p;
    br_pc_plus2 = pc;
    br_imm = imm;
    br_reg_target = rt;
    flag_pending = (pend > 0);
    flagZVN_in = (eff > 0) ? ~f : f;
    holds = 0;
    while (br_ready !== 1'b1 && holds < 8) begin
      @(negedge clk);
      holds++;
    end
    n_chk++;
    if (holds >= 8) begin
      n_fail++;
      $display("FAIL accept_timeout: br_ready=%b required 1", br_ready);
    end
    @(negedge clk);
    br_valid = 1'b0;
    stalls = 0;
    for (int k = 1; k < eff; k++) begin
      n_chk++;
      if (stall !== 1'b1 || redirect_valid !== 1'b0 || flush !== 1'b0) begin
        n_fail++;
        $display("FAIL wait_hold: stall=%b rv=%b flush=%b required 1/0/0",
                 stall, redirect_valid, flush);
      end
      stalls++;
      @(negedge clk);
    end
    if (eff > 0) begin
      flag_pending = 1'b0;
      flagZVN_in = f;
      n_chk++;
      if (stall !== 1'b1 || redirect_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL wait_clear: stall=%b rv=%b required 1/0",
                 stall, redirect_valid);
      end
      stalls++;
      @(negedge clk);
    end
    flag_pending = 1'b0;
    if (stall === 1'b1) stalls++;
    e = sb.pop_front();
    n_chk++;
    if (redirect_valid !== e.mis) begin
      n_fail++;
      $display("FAIL redirect_valid: got %b required %b", redirect_valid, e.mis);
    end
    n_chk++;
    if (flush !== e.mis) begin
      n_fail++;
      $display("FAIL flush: got %b required %b", flush, e.mis);
    end
    n_chk++;
    if (redirect_pc !== e.pc) begin
      n_fail++;
      $display("FAIL redirect_pc: got %h required %h", redirect_pc, e.pc);
    end
    n_chk++;
    if (resolved_taken !== e.taken) begin
      n_fail++;
      $display("FAIL resolved_taken: got %b required %b", resolved_taken, e.taken);
    end
    n_chk++;
    if (branch_count !== e.bc) begin
      n_fail++;
      $display("FAIL branch_count: got %0d required %0d", branch_count, e.bc);
    end
    n_chk++;
    if (mispredict_count !== e.mc) begin
      n_fail++;
      $display("FAIL mispredict_count: got %0d required %0d",
               mispredict_count, e.mc);
    end
    n_chk++;
    if (br_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL resolve_ready: got %b required 0", br_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    br_valid = 1'b0;
    br_cond = '0;
    br_is_reg = 1'b0;
    br_pred_taken = 1'b0;
    br_pc_plus2 = '0;
    br_imm = '0;
    br_reg_target = '0;
    flagZVN_in = '0;
    flag_pending = 1'b0;
    m_rpc = '0;
    m_b = '0;
    m_m = '0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({stall, redirect_valid, flush, resolved_taken} !== 4'b0 ||
        redirect_pc !== '0 || branch_count !== '0 ||
        mispredict_count !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: st=%b rv=%b fl=%b rt=%b pc=%h bc=%0d mc=%0d required all 0",
               stall, redirect_valid, flush, resolved_taken,
               redirect_pc, branch_count, mispredict_count);
    end
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (br_ready !== 1'b1 || stall !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ready: br_ready=%b stall=%b required 1/0",
               br_ready, stall);
    end
  endtask

  task automatic test_basic();
    int s, h;
    issue(3'b001, 1'b0, 1'b0, 16'h0010, 9'd4, 16'h0, 3'b100, 0, s, h);
    issue(3'b000, 1'b0, 1'b0, 16'h0020, 9'd8, 16'h0, 3'b100, 0, s, h);
    n_chk++;
    if (s != 1) begin
      n_fail++;
      $display("FAIL nowait_stall: got %0d cycles required 1", s);
    end
  endtask

  task automatic test_wait();
    int s, h;
    issue(3'b010, 1'b0, 1'b0, 16'h0100, 9'h1F0, 16'h0, 3'b000, 3, s, h);
    n_chk++;
    if (s != 4) begin
      n_fail++;
      $display("FAIL wait_stall_len: got %0d cycles required 4", s);
    end
  endtask

  task automatic test_always_br();
    int s, h;
    issue(3'b111, 1'b1, 1'b0, 16'h0200, 9'd0, 16'hBEEF, 3'b000, 1, s, h);
    n_chk++;
    if (s != 1) begin
      n_fail++;
      $display("FAIL always_nowait: got %0d stall cycles required 1", s);
    end
  endtask

  task automatic test_wrap();
    int s, h;
    issue(3'b111, 1'b0, 1'b0, 16'hFFFE, 9'd2, 16'h0, 3'b000, 0, s, h);
    issue(3'b111, 1'b0, 1'b0, 16'h0004, 9'h1FC, 16'h0, 3'b000, 0, s, h);
  endtask

  task automatic test_conditions();
    int s, h;
    for (int i = 0; i < 24; i++) begin
      issue(3'(i % 8), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 16'($urandom),
            9'($urandom), 16'($urandom), 3'($urandom),
            $urandom_range(0, 2), s, h);
    end
  endtask

  task automatic test_back_to_back();
    int s, h;
    issue(3'b110, 1'b0, 1'b1, 16'h0300, 9'd6, 16'h0, 3'b010, 0, s, h);
    issue(3'b011, 1'b1, 1'b0, 16'h0400, 9'd0, 16'h1234, 3'b001, 0, s, h);
    n_chk++;
    if (h != 1) begin
      n_fail++;
      $display("FAIL back_to_back_hold: got %0d cycles required 1", h);
    end
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    br_valid = 1'b1;
    br_cond = 3'b000;
    br_pred_taken = 1'b1;
    flag_pending = 1'b1;
    flagZVN_in = 3'b000;
    @(negedge clk);
    br_valid = 1'b0;
    n_chk++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL enter_wait: stall=%b required 1", stall);
    end
    rst = 1'b0;
    #1;
    m_rpc = '0;
    m_b = '0;
    m_m = '0;
    n_chk++;
    if ({stall, redirect_valid, flush} !== 3'b0 || branch_count !== '0 ||
        mispredict_count !== '0 || redirect_pc !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_wait: st=%b rv=%b fl=%b bc=%0d mc=%0d pc=%h required 0",
               stall, redirect_valid, flush, branch_count,
               mispredict_count, redirect_pc);
    end
    @(negedge clk);
    flag_pending = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk++;
      if (redirect_valid !== 1'b0 || flush !== 1'b0 || stall !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_pulse: rv=%b fl=%b st=%b required 0",
                 redirect_valid, flush, stall);
      end
    end
  endtask

  task automatic test_saturation();
    int s, h;
    for (int i = 0; i < 17; i++)
      issue(3'b111, 1'b0, 1'b0, 16'(i * 2), 9'd1, 16'h0, 3'b000, 0, s, h);
    issue(3'b111, 1'b0, 1'b1, 16'h0050, 9'd1, 16'h0, 3'b000, 0, s, h);
    n_chk++;
    if (mispredict_count !== CMAX || branch_count !== CMAX) begin
      n_fail++;
      $display("FAIL saturate: mc=%0d bc=%0d required %0d",
               mispredict_count, branch_count, CMAX);
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_wait();
    test_always_br();
    test_wrap();
    test_conditions();
    test_back_to_back();
    test_reset_mid_wait();
    test_saturation();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

endmodule
